regfile_stream_reader: RTL and testbench

Sequencer that drains the 11-entry × 32-bit LPC coefficient register file onto a valid/ready stream. It drives the register file's one-hot read select, captures the combinational read data, and emits one word per entry with index and last markers. It sits between the coefficient register file and downstream consumers such as the quantiser or the serial output packer. It is the read-side counterpart of the one-hot write path.

---
 rtl/regfile_stream_reader.sv | 147 ++++++++++++++
 tb/tb_regfile_stream_reader.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_stream_reader.sv
// Drains the coefficient register file onto a valid/ready stream, one word per entry.
// Define READER_REVERSE_EN to drain from entry DEPTH-1 down to entry 0.
module regfile_stream_reader #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [DEPTH-1:0] rsel,
    input  logic [WIDTH-1:0] rdata,
    output logic [WIDTH-1:0] m_data,
    output logic [3:0]       m_index,
    output logic             m_last,
    output logic             m_valid,
    input  logic             m_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        SEND = 2'd2
    } state_t;

`ifdef READER_REVERSE_EN
    localparam logic [3:0] FIRST_IDX = 4'(DEPTH - 1);
    localparam logic [3:0] LAST_IDX  = 4'd0;
`else
    localparam logic [3:0] FIRST_IDX = 4'd0;
    localparam logic [3:0] LAST_IDX  = 4'(DEPTH - 1);
`endif

    state_t           state_q, state_d;
    logic [3:0]       idx_q, idx_d;
    logic [DEPTH-1:0] rsel_q, rsel_d;
    logic [WIDTH-1:0] m_data_q, m_data_d;
    logic [3:0]       m_index_q, m_index_d;
    logic             m_last_q, m_last_d;
    logic             m_valid_q, m_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [3:0]       next_idx;

    function automatic logic [DEPTH-1:0] onehot(input logic [3:0] i);
        logic [DEPTH-1:0] r;
        r = '0;
        for (int k = 0; k < DEPTH; k++) begin
            r[k] = (i == 4'(k));
        end
        return r;
    endfunction

`ifdef READER_REVERSE_EN
    assign next_idx = idx_q - 4'd1;
`else
    assign next_idx = idx_q + 4'd1;
`endif

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        rsel_d    = rsel_q;
        m_data_d  = m_data_q;
        m_index_d = m_index_q;
        m_last_d  = m_last_q;
        m_valid_d = m_valid_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                rsel_d    = '0;
                m_valid_d = 1'b0;
                if (start) begin
                    state_d = READ;
                    idx_d   = FIRST_IDX;
                    rsel_d  = onehot(FIRST_IDX);
                    busy_d  = 1'b1;
                end
            end
            // rsel is registered, so rdata already reflects the selected entry here
            READ: begin
                m_data_d  = rdata;
                m_index_d = idx_q;
                m_last_d  = (idx_q == LAST_IDX);
                m_valid_d = 1'b1;
                rsel_d    = '0;
                state_d   = SEND;
            end
            SEND: begin
                if (m_valid_q && m_ready) begin
                    m_valid_d = 1'b0;
                    if (m_last_q) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d   = next_idx;
                        rsel_d  = onehot(next_idx);
                        state_d = READ;
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                rsel_d    = '0;
                m_valid_d = 1'b0;
                busy_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            rsel_q    <= '0;
            m_data_q  <= '0;
            m_index_q <= '0;
            m_last_q  <= 1'b0;
            m_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            rsel_q    <= rsel_d;
            m_data_q  <= m_data_d;
            m_index_q <= m_index_d;
            m_last_q  <= m_last_d;
            m_valid_q <= m_valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign rsel    = rsel_q;
    assign m_data  = m_data_q;
    assign m_index = m_index_q;
    assign m_last  = m_last_q;
    assign m_valid = m_valid_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_regfile_stream_reader.sv
// Scoreboard bench for regfile_stream_reader: a register file model feeds rdata, expected
// drains are queued on start acceptance and checked by a negedge monitor.
module tb_regfile_stream_reader;
    localparam int WIDTH = 32;
    localparam int DEPTH = 11;
`ifdef READER_REVERSE_EN
    localparam bit REV = 1'b1;
`else
    localparam bit REV = 1'b0;
`endif

    typedef struct {
        logic [WIDTH-1:0] data;
        logic [3:0]       idx;
        logic             last;
    } item_t;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic             busy, done, m_last, m_valid;
    logic             m_ready;
    logic [DEPTH-1:0] rsel;
    logic [WIDTH-1:0] rdata, m_data;
    logic [3:0]       m_index;

    logic [WIDTH-1:0] regfile [DEPTH];
    item_t            sb [$];
    int               checks = 0;
    int               errors = 0;
    int               ready_mode = 0;

    // reference model state, owned by the monitor
    bit               idle_m = 1'b1;
    logic [DEPTH-1:0] exp_rsel = '0;
    bit               exp_valid = 1'b0;
    bit               exp_done = 1'b0;
    bit               stall_prev = 1'b0;
    logic [WIDTH-1:0] prev_data;
    logic [3:0]       prev_idx;
    logic             prev_last;
    bit               acc, hs, nv, nd;
    logic [DEPTH-1:0] nr;
    item_t            e;

    regfile_stream_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .rsel(rsel), .rdata(rdata), .m_data(m_data), .m_index(m_index),
        .m_last(m_last), .m_valid(m_valid), .m_ready(m_ready)
    );

    always #5 clk = ~clk;

    always_comb begin
        rdata = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (rsel[k]) rdata = rdata | regfile[k];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DEPTH-1:0] oh(input logic [3:0] i);
        logic [DEPTH-1:0] r;
        r = '0;
        r[i] = 1'b1;
        return r;
    endfunction

    function automatic void push_drain();
        int k;
        for (int n = 0; n < DEPTH; n++) begin
            k = REV ? (DEPTH - 1 - n) : n;
            sb.push_back('{regfile[k], 4'(k), (n == DEPTH - 1)});
        end
    endfunction

    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       m_ready = 1'b1;
                1:       m_ready = ($urandom_range(0, 99) >= 50);
                default: m_ready = 1'b0;
            endcase
        end
    end

    // Monitor: compare the cycle, then advance the model across the coming edge.
    initial begin
        forever begin
            @(negedge clk);
            check("rsel", rsel, exp_rsel);
            check("m_valid", m_valid, exp_valid);
            check("busy", busy, !idle_m);
            check("done", done, exp_done);
            if (stall_prev) begin
                check("stall_data", m_data, prev_data);
                check("stall_index", m_index, prev_idx);
                check("stall_last", m_last, prev_last);
            end
            stall_prev = !reset && m_valid && !m_ready;
            prev_data  = m_data;
            prev_idx   = m_index;
            prev_last  = m_last;
            if (reset) begin
                sb.delete();
                idle_m     = 1'b1;
                exp_rsel   = '0;
                exp_valid  = 1'b0;
                exp_done   = 1'b0;
                stall_prev = 1'b0;
            end else begin
                acc = start && idle_m;
                hs  = exp_valid && m_ready;
                nr  = '0;
                nv  = exp_valid || (exp_rsel != '0);
                nd  = 1'b0;
                if (hs) begin
                    nv = 1'b0;
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL handshake: got a word, expected none at %0t", $time);
                    end else begin
                        e = sb.pop_front();
                        check("m_data", m_data, e.data);
                        check("m_index", m_index, e.idx);
                        check("m_last", m_last, e.last);
                        if (e.last) begin
                            idle_m = 1'b1;
                            nd     = 1'b1;
                        end else if (sb.size() > 0) begin
                            nr = oh(sb[0].idx);
                        end
                    end
                end
                if (acc) begin
                    push_drain();
                    idle_m = 1'b0;
                    nr     = oh(sb[0].idx);
                end
                exp_rsel  = nr;
                exp_valid = nv;
                exp_done  = nd;
            end
        end
    end

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk);
            #2;
            if (idle_m) break;
        end
        checks++;
        if (!idle_m) begin
            errors++;
            $display("FAIL drain_timeout: still busy after %0d cycles, expected idle", budget);
        end
    endtask

    initial begin
        int i;
        for (int k = 0; k < DEPTH; k++) regfile[k] = 32'h1000_0000 + 32'(k);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_m_data", m_data, 0);
        check("reset_m_index", m_index, 0);
        check("reset_m_last", m_last, 0);

        // full-rate drain
        ready_mode = 0;
        pulse_start();
        wait_idle(100);

        // random backpressure
        ready_mode = 1;
        pulse_start();
        wait_idle(400);

        // start re-pulsed mid-drain is ignored
        ready_mode = 0;
        pulse_start();
        repeat (10) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_idle(100);

        // reset while word 7 is stalled in SEND
        ready_mode = 0;
        pulse_start();
        repeat (14) @(posedge clk);
        ready_mode = 2;
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        ready_mode = 0;
        repeat (3) @(posedge clk);
        pulse_start();
        wait_idle(100);

        // back-to-back: start during the done cycle
        ready_mode = 0;
        pulse_start();
        for (i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (done) break;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL done_wait: got done=%0b, expected 1 within 100 cycles", done);
        end
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_idle(100);

        // random contents with random backpressure
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < DEPTH; k++) regfile[k] = $urandom;
            ready_mode = 1;
            pulse_start();
            wait_idle(400);
        end
        ready_mode = 0;
        repeat (3) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL leftover_words: got %0d pending, expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
